// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Results are committed in one step at completion, so diff/bout/overflow never show partial values.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt, dig_wide;
  logic [DIGIT-1:0] dig;
  logic             carry, borrow, borrow_nxt;
  logic             a_msb, b_msb;
  logic [CW-1:0]    count;
  logic             last;

  // Handshake: start is sampled only in S_IDLE; busy is high for the N RUN cycles,
  // then done pulses for exactly one cycle while busy is low; start is ignored otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // One digit of a + ~b + !borrow; carry-out of the digit is the inverse of the borrow.
  always_comb begin
    {carry, dig} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, ~b_sh[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, ~borrow};
    borrow_nxt   = ~carry;
    dig_wide     = WIDTH'(dig);
    res_nxt      = (res >> DIGIT) | (dig_wide << (WIDTH - DIGIT));
    last         = (count == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      borrow   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      count    <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == S_IDLE && start) begin
      a_sh   <= a;
      b_sh   <= b;
      res    <= '0;
      borrow <= bin;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
      count  <= '0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res    <= res_nxt;
      borrow <= borrow_nxt;
      count  <= last ? '0 : count + CW'(1);
      if (last) begin
        diff     <= res_nxt;
        bout     <= borrow_nxt;
        // Sign test uses the operand MSBs captured at acceptance; bin plays no part.
        overflow <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
      end
    end
  end

endmodule
